// File: rtl/apc_rr_sender.sv
// Round-robin srdy/drdy arbiter driving one APC phase-change channel.
// Optional ack watchdog: define APC_RR_TIMEOUT_EN.
module apc_rr_sender #(
    parameter int inputs         = 4,
    parameter int width          = 32,
    parameter int tag_w          = 2,
    parameter int timeout_cycles = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    output logic                    p_ph_send,
    input  logic                    p_ph_ack,
    output logic [width-1:0]        p_data,
    output logic [tag_w-1:0]        p_tag,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic {
        s_idle,
        s_wait
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             ack_meta;
    logic             sync_ack;
    logic [tag_w-1:0] ptr;
    logic [tag_w-1:0] grant;
    logic             found;
    logic             take;
    logic [width-1:0] sel_word;
    int               idx;

    // xp_synchronizer: raw p_ph_ack is used nowhere else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta <= 1'b0;
            sync_ack <= 1'b0;
        end else begin
            ack_meta <= p_ph_ack;
            sync_ack <= ack_meta;
        end
    end

    // first requester above ptr, wrapping modulo inputs
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 1; k <= inputs; k++) begin
            idx = (int'(ptr) + k) % inputs;
            if (!found && c_srdy[tag_w'(idx)]) begin
                found = 1'b1;
                grant = tag_w'(idx);
            end
        end
    end

    assign take     = (state == s_idle) && found;
    assign sel_word = c_data[int'(grant)*width +: width];
    assign busy     = (state == s_wait);

    always_comb begin
        c_drdy = '0;
        if (take) begin
            c_drdy[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            s_idle: begin
                if (found) begin
                    state_nx = s_wait;
                end
            end
            s_wait: begin
                if (sync_ack == p_ph_send) begin
                    state_nx = s_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= s_idle;
            p_ph_send <= 1'b0;
            p_data    <= '0;
            p_tag     <= '0;
            ptr       <= tag_w'(inputs - 1);
        end else begin
            state <= state_nx;
            if (take) begin
                p_data    <= sel_word;
                p_tag     <= grant;
                ptr       <= grant;
                p_ph_send <= ~p_ph_send;
            end
        end
    end

`ifdef APC_RR_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] TO = CW'(timeout_cycles);

    logic [CW-1:0] to_cnt;
    logic          to_err;

    // saturates at the limit; the transfer is never abandoned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else if (take) begin
            to_cnt <= '0;
        end else if (busy && to_cnt != TO) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt + 1'b1 == TO) begin
                to_err <= 1'b1;
            end
        end
    end

    assign timeout_err = to_err;
`else
    localparam int unused_timeout = timeout_cycles;

    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/apc_rr_sender.md
# apc_rr_sender

Round-robin arbiter and sequencer that shares one asynchronous phase-change (APC) channel among several srdy/drdy producers. It sits on the sending side of a clock-domain crossing, upstream of the APC-to-srdy/drdy receiver in the destination domain. It selects one requester, captures its word and source index, toggles the send phase, and holds the channel until the synchronized ack phase catches up.

## Interface
Parameters:
- inputs, default 4: number of srdy/drdy requesters, 2..16.
- width, default 32: data word width.
- tag_w, default 2: width of p_tag; must equal clog2(inputs).
- timeout_cycles, default 1024: ack wait limit, used only when the timeout feature is compiled in.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- c_srdy  in  inputs  per-requester source ready.
- c_drdy  out  inputs  per-requester accept; one-hot or zero.
- c_data  in  inputs*width  requester words; requester i occupies bits [i*width +: width].
- p_ph_send  out  1  send phase; toggles once per transfer.
- p_ph_ack  in  1  ack phase from the receiving domain; asynchronous to clk.
- p_data  out  width  captured word; stable while a transfer is outstanding.
- p_tag  out  tag_w  index of the requester that produced p_data.
- busy  out  1  high while in s_wait.
- timeout_err  out  1  sticky ack-timeout flag.

## Operation
- p_ph_ack passes through a 2-flop xp_synchronizer to give sync_ack. No other logic uses raw p_ph_ack.
- State machine:
  - s_idle:
    - If any c_srdy bit is high, grant the first set bit searching upward from ptr+1, modulo inputs.
    - Assert c_drdy[grant] combinationally in the same cycle.
    - On that clock edge: p_data <= selected word, p_tag <= grant, ptr <= grant, p_ph_send <= ~p_ph_send, go to s_wait.
  - s_wait:
    - c_drdy is all zeros.
    - When sync_ack == p_ph_send, go to s_idle.
    - p_data and p_tag hold their values.
- A new grant is allowed in the s_idle cycle immediately after s_wait exits.
- Only one transfer is outstanding at a time.
- The arbiter ignores changes to c_srdy while in s_wait.
- The arbiter samples c_data only in the grant cycle.
- busy equals (state == s_wait).

## Timing
- Reset values:
  - state = s_idle, p_ph_send = 0, p_data = 0, p_tag = 0.
  - ptr = inputs-1, so requester 0 wins first.
  - c_drdy = 0, busy = 0, timeout_err = 0, synchronizer flops = 0.
- Grant-to-send latency: p_ph_send toggles at the edge ending the grant cycle.
- Completion: s_wait exits 2 clk edges after p_ph_ack settles to the new phase (synchronizer delay), plus 1 edge for the state update.
- Round trip per transfer is bounded below by 4 clk cycles on the sender side.
- Simultaneous requests: strict rotation; a requester that is continuously asserting waits at most inputs-1 transfers.
- A single requester asserting alone is granted on every s_idle visit.
- An ack toggle while in s_idle is a protocol violation. It is ignored; the block takes no state change and raises no error.
- Reset asserted mid-transfer clears everything immediately. The receiving domain must also be reset so that both phases restart at 0.

## Configuration
- APC_RR_TIMEOUT_EN defined:
  - A counter of width clog2(timeout_cycles+1) clears on entry to s_wait and increments each s_wait cycle.
  - When it reaches timeout_cycles, timeout_err is set and stays set until reset_n.
  - The FSM keeps waiting; it never abandons a transfer.
- APC_RR_TIMEOUT_EN undefined:
  - No counter is built.
  - timeout_err is tied to 0.
  - timeout_cycles is unused.

## Test plan
- Reset, then c_srdy=4'b0001 with data 0xA5A5_0000 and a loopback ack delayed 3 cycles:
  - p_ph_send goes 0->1, p_data=0xA5A5_0000, p_tag=0.
  - c_drdy pulses 1 cycle.
  - busy falls 3 cycles after ack toggles.
- c_srdy=4'b1111 held, loopback ack: grants in order 0,1,2,3,0,1; p_tag matches each grant; each transfer toggles p_ph_send exactly once.
- c_srdy=4'b1010 after a grant to 1: next grant is 3, then 1.
- Requester 2 changes c_data while its transfer is in s_wait: p_data is unchanged until the next grant.
- With APC_RR_TIMEOUT_EN and timeout_cycles=16, ack withheld:
  - timeout_err rises exactly 16 s_wait cycles after entry and busy stays 1.
  - A later ack completes the transfer and timeout_err stays 1.
- reset_n pulsed low mid s_wait with p_ph_send=1: all outputs return to reset values asynchronously, and the next grant goes to requester 0.
